// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its operand sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    GET_A  = 2'd0,
    GET_B  = 2'd1,
    EXEC   = 2'd2,
    RESULT = 2'd3
  } seq_state_t;

endpackage

// File: rtl/alu_operand_sequencer_if.sv
// Operand-in / result-out handshake bundle for the operand sequencer.
// Latency: n/a (wiring only).
// Backpressure: in_ready/out_ready carry the valid-ready stalls.
interface alu_operand_sequencer_if #(
  parameter int WIDTH  = 4,
  parameter int RWIDTH = 2*WIDTH
) ();
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic [1:0]        in_op;
  logic              out_valid;
  logic              out_ready;
  logic [RWIDTH-1:0] out_R;
  logic [3:0]        out_flags;

  // Sequencer side: consumes operand beats, produces results.
  modport slave (
    input  in_valid, in_data, in_op, out_ready,
    output in_ready, out_valid, out_R, out_flags
  );

  // Environment side: produces operand beats, consumes results.
  modport master (
    output in_valid, in_data, in_op, out_ready,
    input  in_ready, out_valid, out_R, out_flags
  );
endinterface

// File: rtl/alu.sv
// Combinational 4-op ALU (MUL/SUB/AND/XOR) with Z/N/C/V flags.
// Latency: 0 cycles, purely combinational.
// Backpressure: none.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int RWIDTH = 2*WIDTH
) (
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  input  logic [1:0]        OP,
  output logic [RWIDTH-1:0] R,
  output logic              Z,
  output logic              N,
  output logic              C,
  output logic              V
);
  logic [WIDTH-1:0] diff;

  assign diff = A - B;

  // Result plus carry/overflow per opcode; C is borrow for SUB and
  // "product does not fit in WIDTH bits" for MUL.
  always_comb begin
    R = '0;
    C = 1'b0;
    V = 1'b0;
    unique case (OP)
      OP_MUL: begin
        R = RWIDTH'(A) * RWIDTH'(B);
        C = |R[RWIDTH-1:WIDTH];
      end
      OP_SUB: begin
        R = RWIDTH'(A) - RWIDTH'(B);
        C = (A < B);
        V = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND: R = RWIDTH'(A & B);
      OP_XOR: R = RWIDTH'(A ^ B);
      default: R = '0;
    endcase
  end

  assign Z = (R == '0);
  assign N = R[RWIDTH-1];

endmodule

// File: rtl/alu_operand_sequencer.sv
// Collects A then B+opcode, drives the ALU for one cycle, holds the result.
// Latency: result valid one cycle after the B beat is accepted.
// Backpressure: in_ready low outside GET_A/GET_B; result held while out_ready low.
module alu_operand_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int RWIDTH = 2*WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  alu_operand_sequencer_if.slave  bus,
  output logic [WIDTH-1:0]        alu_A,
  output logic [WIDTH-1:0]        alu_B,
  output logic [1:0]              alu_OP,
  input  logic [RWIDTH-1:0]       alu_R,
  input  logic                    alu_Z,
  input  logic                    alu_N,
  input  logic                    alu_C,
  input  logic                    alu_V,
  output logic [7:0]              op_count
);
  seq_state_t state, state_nxt;
  logic       take_a, take_b, deliver;

  assign take_a  = bus.in_valid && bus.in_ready && (state == GET_A);
  assign take_b  = bus.in_valid && bus.in_ready && (state == GET_B);
  assign deliver = bus.out_valid && bus.out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= GET_A;
    else        state <= state_nxt;
  end

  // Next state; clear overrides every transition.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = GET_A;
    end else begin
      unique case (state)
        GET_A:   if (bus.in_valid)  state_nxt = GET_B;
        GET_B:   if (bus.in_valid)  state_nxt = EXEC;
        EXEC:                       state_nxt = RESULT;
        RESULT:  if (bus.out_ready) state_nxt = GET_A;
        default:                    state_nxt = GET_A;
      endcase
    end
  end

  // Handshake outputs decoded from state only (clear just masks them).
  always_comb begin
    bus.in_ready  = !clear && ((state == GET_A) || (state == GET_B));
    bus.out_valid = !clear && (state == RESULT);
  end

  // Operand/opcode capture; held until the next capture beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_A  <= '0;
      alu_B  <= '0;
      alu_OP <= OP_MUL;
    end else begin
      if (take_a) alu_A <= bus.in_data;
      if (take_b) begin
        alu_B  <= bus.in_data;
        alu_OP <= bus.in_op;
      end
    end
  end

  // Latch the settled ALU result at the end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_R     <= '0;
      bus.out_flags <= '0;
    end else if (!clear && (state == EXEC)) begin
      bus.out_R             <= alu_R;
      bus.out_flags[FLAG_Z] <= alu_Z;
      bus.out_flags[FLAG_N] <= alu_N;
      bus.out_flags[FLAG_C] <= alu_C;
      bus.out_flags[FLAG_V] <= alu_V;
    end
  end

  // Saturating count of delivered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          op_count <= '0;
    else if (deliver && op_count != 8'hFF) op_count <= op_count + 8'd1;
  end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
`timescale 1ns/1ps
module tb_alu_operand_sequencer;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] alu_A, alu_B;
  logic [1:0] alu_OP;
  logic [7:0] alu_R;
  logic       alu_Z, alu_N, alu_C, alu_V;
  logic [7:0] op_count;

  int checks = 0;
  int errors = 0;

  alu_operand_sequencer_if #(.WIDTH(4), .RWIDTH(8)) bus ();

  alu_operand_sequencer #(.WIDTH(4), .RWIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus),
    .alu_A(alu_A), .alu_B(alu_B), .alu_OP(alu_OP), .alu_R(alu_R),
    .alu_Z(alu_Z), .alu_N(alu_N), .alu_C(alu_C), .alu_V(alu_V),
    .op_count(op_count)
  );

  alu #(.WIDTH(4), .RWIDTH(8)) u_alu (
    .A(alu_A), .B(alu_B), .OP(alu_OP), .R(alu_R),
    .Z(alu_Z), .N(alu_N), .C(alu_C), .V(alu_V)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference ALU in plain integer arithmetic: returns {R[7:0], Z, N, C, V}.
  function automatic logic [11:0] alu_model(input int a, input int b, input int op);
    int r, c, v, sa, sb, d;
    c = 0;
    v = 0;
    case (op)
      0: begin
        r = a * b;
        c = (r > 15) ? 1 : 0;
      end
      1: begin
        r  = (a - b + 256) % 256;
        c  = (a < b) ? 1 : 0;
        sa = (a >= 8) ? a - 16 : a;
        sb = (b >= 8) ? b - 16 : b;
        d  = sa - sb;
        v  = (d < -8 || d > 7) ? 1 : 0;
      end
      2: r = a & b;
      default: r = a ^ b;
    endcase
    return {r[7:0], (r == 0), (r >= 128), c[0], v[0]};
  endfunction

  // Transaction-level model: where we are in the A/B/compute/hold cycle and what it holds.
  int         m_phase;
  logic [3:0] m_a, m_b;
  logic [1:0] m_op;
  logic [7:0] m_r;
  logic [3:0] m_f;
  int         m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_a = 0; m_b = 0; m_op = 0; m_r = 0; m_f = 0; m_cnt = 0;
    end else if (clear) begin
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (bus.in_valid) begin m_a = bus.in_data; m_phase = 1; end
        1: if (bus.in_valid) begin m_b = bus.in_data; m_op = bus.in_op; m_phase = 2; end
        2: begin {m_r, m_f} = alu_model(m_a, m_b, m_op); m_phase = 3; end
        default: if (bus.out_ready) begin
          if (m_cnt < 255) m_cnt++;
          m_phase = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready",  bus.in_ready,  !clear && (m_phase < 2));
      chk("out_valid", bus.out_valid, !clear && (m_phase == 3));
      chk("out_R",     bus.out_R,     m_r);
      chk("out_flags", bus.out_flags, m_f);
      chk("op_count",  op_count,      m_cnt);
      chk("alu_A",     alu_A,         m_a);
      chk("alu_B",     alu_B,         m_b);
      chk("alu_OP",    alu_OP,        m_op);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_first;
    int t_second;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_op     = '0;
    bus.out_ready = 1'b0;

    chk("model_mul", alu_model(3, 2, 0),   {8'h06, 4'b0000});
    chk("model_sub", alu_model(2, 5, 1),   {8'hFD, 4'b0110});
    chk("model_and", alu_model(13, 11, 2), {8'h09, 4'b0000});
    chk("model_m16", alu_model(4, 4, 0),   {8'h10, 4'b0010});

    cyc(); cyc();
    rst_n = 1'b1;
    chk("rst_in_ready",  bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_R",     bus.out_R, 0);
    chk("rst_flags",     bus.out_flags, 0);
    chk("rst_count",     op_count, 0);

    // MUL 3*2
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = 4'd3; cyc();
    bus.in_data = 4'd2; bus.in_op = OP_MUL; cyc();
    bus.in_valid = 1'b0;
    chk("mul_exec_no_valid", bus.out_valid, 0);
    cyc();
    chk("mul_valid", bus.out_valid, 1);
    chk("mul_R", bus.out_R, 8'h06);
    chk("mul_Z", bus.out_flags[FLAG_Z], 0);
    cyc();
    chk("mul_count", op_count, 1);
    chk("mul_back_to_a", bus.in_ready, 1);

    // Zero flag
    bus.in_valid = 1'b1; bus.in_data = 4'd0; cyc();
    bus.in_data = 4'd0; bus.in_op = OP_MUL; cyc();
    bus.in_valid = 1'b0; cyc();
    chk("zero_R", bus.out_R, 8'h00);
    chk("zero_Z", bus.out_flags[FLAG_Z], 1);
    cyc();
    chk("zero_count", op_count, 2);

    // Backpressure on AND, with upstream pushing during the hold
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 4'd13; cyc();
    bus.in_data = 4'd11; bus.in_op = OP_AND; cyc();
    bus.in_data = 4'd7; cyc();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_R", bus.out_R, 8'h09);
      chk("bp_in_ready", bus.in_ready, 0);
      cyc();
    end
    bus.out_ready = 1'b1; bus.in_valid = 1'b0; cyc();
    chk("bp_released", bus.out_valid, 0);
    chk("bp_get_a", bus.in_ready, 1);
    chk("bp_count", op_count, 3);

    // Back-to-back XOR then MUL, streaming
    bus.in_valid = 1'b1; bus.in_data = 4'd13; cyc();
    bus.in_data = 4'd11; bus.in_op = OP_XOR; cyc();
    cyc();
    chk("b2b_R1", bus.out_R, 8'h06);
    t_first = int'($time);
    bus.in_data = 4'd4; cyc();
    cyc();
    bus.in_op = OP_MUL; cyc();
    cyc();
    chk("b2b_valid2", bus.out_valid, 1);
    chk("b2b_R2", bus.out_R, 8'h10);
    t_second = int'($time);
    chk("b2b_spacing", t_second - t_first, 40);
    bus.in_valid = 1'b0; cyc();
    chk("b2b_count", op_count, 5);

    // clear while waiting for B: the next beat becomes A
    bus.in_valid = 1'b1; bus.in_data = 4'd5; cyc();
    clear = 1'b1; bus.in_data = 4'd9; bus.in_op = OP_SUB;
    #1 chk("clr_in_ready", bus.in_ready, 0);
    cyc();
    clear = 1'b0;
    chk("clr_no_result", bus.out_valid, 0);
    chk("clr_count", op_count, 5);
    chk("clr_a_kept", alu_A, 4'd5);
    bus.in_data = 4'd6; cyc();
    chk("clr_new_a", alu_A, 4'd6);
    bus.in_data = 4'd2; bus.in_op = OP_MUL; cyc();
    bus.in_valid = 1'b0; cyc();
    chk("clr_R", bus.out_R, 8'h0C);
    chk("clr_count_hold", op_count, 5);
    cyc();
    chk("clr_count_after", op_count, 6);

    // Drive the counter into saturation
    bus.in_valid = 1'b1;
    for (int i = 0; i < 260; i++) begin
      bus.in_data = i[3:0]; cyc();
      bus.in_data = i[7:4]; bus.in_op = i[1:0]; cyc();
      cyc();
      cyc();
    end
    bus.in_valid = 1'b0;
    chk("sat_count", op_count, 255);

    // Async reset while holding a result
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 4'd2; cyc();
    bus.in_data = 4'd5; bus.in_op = OP_SUB; cyc();
    bus.in_valid = 1'b0; cyc();
    chk("sub_R", bus.out_R, 8'hFD);
    chk("sub_flags", bus.out_flags, 4'b0110);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_out_R", bus.out_R, 0);
    chk("arst_count", op_count, 0);
    chk("arst_alu_A", alu_A, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("arst_in_ready", bus.in_ready, 1);
    cyc();
    chk("arst_in_ready2", bus.in_ready, 1);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
